fifo_rd_streamer: RTL and testbench
===================================

FIFO_RD_STREAMER -- requirements
Module: fifo_rd_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default FIFO_DATA_WIDTH from async_fifo_pkg; width of FIFO read data and stream data.
REQ-002 Parameter CNT_WIDTH, default 16; width of burst length, remaining count and pop counter.
REQ-003 Single clock and reset: rclk is the only clock; rrst is a synchronous, active-high reset sampled on posedge rclk.
REQ-004 rclk  in  1  read-domain clock; all state updates on posedge.
REQ-005 rrst  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle request to read a burst of len words.
REQ-007 len  in  CNT_WIDTH  burst length; sampled only when start is accepted.
REQ-008 busy  out  1  high from the cycle after start is accepted until the done pulse is issued, inclusive.
REQ-009 done  out  1  one-cycle pulse when the burst is complete.
REQ-010 rempty  in  1  FIFO read-side empty flag.
REQ-011 rdata  in  DATA_WIDTH  FIFO read data; first-word fall-through, valid whenever rempty=0.
REQ-012 rinc  out  1  FIFO pop strobe; the pointer advances at the posedge where rinc=1.
REQ-013 m_valid  out  1  stream data valid.
REQ-014 m_data  out  DATA_WIDTH  stream data.
REQ-015 m_ready  in  1  stream sink ready.
REQ-016 pop_count  out  CNT_WIDTH  total FIFO pops since reset; wraps modulo 2^CNT_WIDTH.

Function
REQ-017 The block SHALL use these states: IDLE, RUN, FLUSH.
- IDLE: start=1 -> RUN, latching remaining=len.
- RUN: remaining reaches 0 -> FLUSH.
- FLUSH: buffer occupancy 0 -> IDLE with done=1 in that cycle.
REQ-018 Start with len=0 SHALL still pass through RUN and FLUSH.
- No pop occurs.
- done pulses 2 cycles after start.
REQ-019 start while busy=1 SHALL be ignored, with no effect on remaining or len.
REQ-020 The output buffer SHALL be a 2-entry FIFO, registered, with occupancy occ in 0..2.
- m_valid = (occ != 0).
- m_data = head entry.
REQ-021 rinc SHALL be combinational: state=RUN AND rempty=0 AND remaining!=0 AND occ<2.
REQ-022 When rinc=1, rdata SHALL be written into the buffer tail at the same posedge, remaining decrements by 1, and pop_count increments by 1.
REQ-023 Latency: a word popped at posedge N SHALL appear on m_data with m_valid=1 after posedge N if the buffer was empty.
REQ-024 The buffer head SHALL be removed at a posedge where m_valid=1 and m_ready=1.
- Simultaneous write and remove leaves occ unchanged.
- m_data and m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-025 Sustained throughput SHALL be 1 word/cycle when the FIFO is non-empty and m_ready=1.
REQ-026 With m_ready=0, at most 2 words SHALL be popped; rinc then stays 0 until a word is accepted.
REQ-027 rempty=1 in RUN SHALL hold rinc=0 with no state change; popping resumes the cycle rempty falls.
REQ-028 Word order on m_data SHALL equal FIFO pop order; no word is lost or duplicated.

Reset
REQ-029 On rrst=1 at posedge rclk, the block SHALL reset to: state=IDLE, occ=0, remaining=0, pop_count=0, busy=0, done=0, m_valid=0, m_data=0.
REQ-030 rinc SHALL be 0 during any cycle in which rrst=1.
REQ-031 Reset mid-burst SHALL discard buffered words.
- Words not yet popped remain in the FIFO.
- No done pulse is issued for the aborted burst.

Verification
REQ-032 Scenario: FIFO preloaded with 0x11,0x22,0x33; start len=3; m_ready=1 -> rinc high 3 consecutive cycles; m_data 0x11,0x22,0x33 on consecutive cycles; one done pulse; pop_count=3.
REQ-033 Scenario: 4 words in FIFO; len=4; m_ready=0 for 10 cycles, then 1 -> exactly 2 pops while stalled; m_data holds the first word stable; all 4 words delivered in order afterwards.
REQ-034 Scenario: FIFO empty; start len=2; push 0xA5 at cycle 5 and 0x5A at cycle 20 -> rinc=0 while rempty=1; both words delivered; done follows the last accept.
REQ-035 Scenario: start len=0 -> no rinc; done exactly 2 cycles after start; busy high for those 2 cycles.
REQ-036 Scenario: rrst asserted after 2 of 5 words popped -> all outputs at reset values next cycle; no done; 3 words remain in the FIFO.
REQ-037 Scenario: second start pulse while busy with len=7 -> ignored; the original burst count completes; a single done pulse.

Source files
------------

// File: rtl/fifo_rd_streamer_if.sv
// Read-side bundle between the streamer, the FIFO read port and the stream sink.
// master = streamer side, slave = FIFO/sink environment side.
interface fifo_rd_streamer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rempty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rinc;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  rempty, rdata, m_ready,
        output rinc, m_valid, m_data
    );

    modport slave (
        output rempty, rdata, m_ready,
        input  rinc, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rd_streamer.sv
// Pops a requested burst of words from a first-word-fall-through FIFO and
// forwards them on a valid/ready stream through a 2-entry registered buffer.
package async_fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 8;
endpackage

module fifo_rd_streamer
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pop_count,
    fifo_rd_streamer_if.master   bus
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;
    logic                  push;
    logic                  pop;

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN:   if (remaining == '0) state_nxt = FLUSH;
            FLUSH: begin
                if (occ == 2'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pop only while room remains in the buffer, so it can never overflow.
    assign push = (state == RUN) && !bus.rempty && (remaining != '0)
                  && (occ != 2'd2) && !rrst;
    assign pop  = (occ != 2'd0) && bus.m_ready;

    assign busy        = (state != IDLE);
    assign bus.rinc    = push;
    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = mem[rd_ptr];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state     <= IDLE;
            remaining <= '0;
            pop_count <= '0;
            occ       <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) remaining <= len;
            else if (push)              remaining <= remaining - 1'b1;
            if (push) begin
                mem[wr_ptr] <= bus.rdata;
                wr_ptr      <= ~wr_ptr;
                pop_count   <= pop_count + 1'b1;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: queue-based FIFO/stream model, table of bursts,
// hand-written stall/empty/reset/restart sequences and randomized bursts.
module tb_fifo_rd_streamer;
    localparam int DW = 8;
    localparam int CW = 4;

    typedef struct {
        int len;
        int pre;
        int exp_pops;
        int exp_done;
    } vec_t;

    logic          rclk = 1'b0;
    logic          rrst;
    logic          start;
    logic [CW-1:0] len;
    logic          busy;
    logic          done;
    logic [CW-1:0] pop_count;

    fifo_rd_streamer_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_streamer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .rclk(rclk), .rrst(rrst), .start(start), .len(len), .busy(busy),
        .done(done), .pop_count(pop_count), .bus(bus)
    );

    always #5 rclk = ~rclk;

    logic [DW-1:0] fifo[$];
    logic [DW-1:0] pend[$];
    logic [DW-1:0] acc_log[$];
    logic [DW-1:0] pop_log[$];
    int            ph;
    int            m_rem;
    logic [CW-1:0] m_pops;
    int            n_vec;
    int            n_bad;
    bit            chk_en;
    bit            last_done;
    int            done_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive, check against the model just before the edge,
    // then advance model and environment FIFO as the edge would.
    task automatic step(input bit st, input int ln, input bit rdy, input bit rs);
        bit e_rinc;
        bit e_valid;
        bit e_busy;
        bit e_done;
        bit acc;
        start       = st;
        len         = CW'(ln);
        bus.m_ready = rdy;
        rrst        = rs;
        bus.rempty  = (fifo.size() == 0);
        bus.rdata   = (fifo.size() != 0) ? fifo[0] : '0;
        #1;
        e_rinc  = !rs && ph == 1 && m_rem != 0 && fifo.size() != 0 && pend.size() < 2;
        e_valid = pend.size() != 0;
        e_busy  = ph != 0;
        e_done  = ph == 2 && pend.size() == 0;
        if (chk_en) begin
            chk("rinc", 32'(bus.rinc), 32'(e_rinc));
            chk("m_valid", 32'(bus.m_valid), 32'(e_valid));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("pop_count", 32'(pop_count), 32'(m_pops));
            if (e_valid) chk("m_data", 32'(bus.m_data), 32'(pend[0]));
        end
        last_done = (done === 1'b1);
        if (last_done) done_cnt++;
        if (bus.m_valid === 1'b1 && rdy && !rs) acc_log.push_back(bus.m_data);
        if (bus.rinc === 1'b1 && fifo.size() != 0) pop_log.push_back(fifo[0]);
        if (rs) begin
            ph = 0; m_rem = 0; m_pops = '0; pend.delete();
        end else begin
            acc = e_valid && rdy;
            case (ph)
                0: if (st) begin ph = 1; m_rem = ln; end
                1: if (m_rem == 0) ph = 2;
                2: if (pend.size() == 0) ph = 0;
                default: ph = 0;
            endcase
            if (acc) void'(pend.pop_front());
            if (e_rinc) begin
                pend.push_back(fifo[0]);
                m_rem--;
                m_pops++;
            end
        end
        if (bus.rinc === 1'b1 && fifo.size() != 0) void'(fifo.pop_front());
        @(negedge rclk);
    endtask

    task automatic run_until_done(input int rdy_pct, input int push_pct, input int budget,
                                  output int at);
        at = -1;
        for (int c = 1; c < budget; c++) begin
            if (push_pct > 0 && fifo.size() < 20 && $urandom_range(99) < push_pct)
                fifo.push_back(DW'($urandom));
            step(0, 0, $urandom_range(99) < rdy_pct, 0);
            if (last_done) begin at = c; break; end
        end
        if (at < 0) begin
            n_vec++; n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic run_burst(input int ln, input int rdy_pct, input int push_pct,
                             input int budget, output int at);
        acc_log.delete(); pop_log.delete(); done_cnt = 0;
        step(1, ln, $urandom_range(99) < rdy_pct, 0);
        run_until_done(rdy_pct, push_pct, budget, at);
    endtask

    task automatic cmp_words(input string nm, input logic [DW-1:0] exp_q[$]);
        chk({nm, "_count"}, 32'(acc_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++)
            chk(nm, 32'(acc_log[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t          tbl[5];
        logic [DW-1:0] exp_q[$];
        logic [CW-1:0] base;
        int            at;
        int            last_acc;
        int            ln;

        n_vec = 0; n_bad = 0; chk_en = 0; ph = 0; m_rem = 0; m_pops = '0;
        start = 0; len = '0; rrst = 1; bus.m_ready = 0; bus.rempty = 1; bus.rdata = '0;
        @(negedge rclk);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk_en = 1;

        // Reset state; rinc must stay low during reset even with data present.
        fifo.push_back(8'h77);
        step(0, 0, 1, 1);
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_m_data", 32'(bus.m_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pop_count", 32'(pop_count), 0);
        fifo.delete();

        // {len, preloaded words, pops, cycle of done relative to start}
        tbl[0] = '{3, 3, 3, 5};
        tbl[1] = '{0, 2, 0, 2};
        tbl[2] = '{1, 4, 1, 3};
        tbl[3] = '{5, 5, 5, 7};
        tbl[4] = '{2, 5, 2, 4};
        for (int v = 0; v < 5; v++) begin
            fifo.delete(); exp_q.delete();
            for (int k = 0; k < tbl[v].pre; k++) begin
                fifo.push_back(DW'(16 * v + k + 17));
                if (k < tbl[v].exp_pops) exp_q.push_back(DW'(16 * v + k + 17));
            end
            base = m_pops;
            run_burst(tbl[v].len, 100, 0, 40, at);
            chk("tbl_done_at", 32'(at), 32'(tbl[v].exp_done));
            chk("tbl_pop_count", 32'(pop_count), 32'(CW'(base + tbl[v].exp_pops)));
            chk("tbl_fifo_left", 32'(fifo.size()), 32'(tbl[v].pre - tbl[v].exp_pops));
            cmp_words("tbl_word", exp_q);
            step(0, 0, 1, 0); step(0, 0, 1, 0);
            chk("tbl_done_cnt", 32'(done_cnt), 1);
        end

        // Sink stalled for 10 cycles: only two pops may happen.
        fifo = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        acc_log.delete(); pop_log.delete(); done_cnt = 0;
        step(1, 4, 0, 0);
        for (int c = 1; c < 10; c++) step(0, 0, 0, 0);
        chk("stall_pops", 32'(pop_log.size()), 2);
        run_until_done(100, 0, 40, at);
        exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        cmp_words("stall_word", exp_q);

        // Empty FIFO with late arrivals.
        fifo.delete(); acc_log.delete(); pop_log.delete(); done_cnt = 0;
        step(1, 2, 1, 0);
        at = -1; last_acc = -1;
        for (int c = 1; c < 40; c++) begin
            if (c == 5)  fifo.push_back(8'hA5);
            if (c == 20) fifo.push_back(8'h5A);
            ln = acc_log.size();
            step(0, 0, 1, 0);
            if (acc_log.size() != ln) last_acc = c;
            if (last_done) begin at = c; break; end
        end
        exp_q = '{8'hA5, 8'h5A};
        cmp_words("empty_word", exp_q);
        chk("empty_done_at", 32'(at), 32'(last_acc + 1));

        // Reset after two of five words popped.
        fifo = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        done_cnt = 0;
        step(1, 5, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("abort_m_valid", 32'(bus.m_valid), 0);
        chk("abort_m_data", 32'(bus.m_data), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pop_count", 32'(pop_count), 0);
        chk("abort_fifo_left", 32'(fifo.size()), 3);
        for (int c = 0; c < 4; c++) step(0, 0, 1, 0);
        chk("abort_done_cnt", 32'(done_cnt), 0);
        fifo.delete();

        // Second start while busy is ignored.
        fifo.delete();
        for (int k = 0; k < 9; k++) fifo.push_back(DW'(8'h40 + k));
        acc_log.delete(); pop_log.delete(); done_cnt = 0;
        step(1, 3, 1, 0);
        step(1, 7, 1, 0);
        run_until_done(100, 0, 40, at);
        step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
        chk("restart_pops", 32'(pop_log.size()), 3);
        chk("restart_fifo_left", 32'(fifo.size()), 6);
        chk("restart_done_cnt", 32'(done_cnt), 1);
        fifo.delete();

        // Randomized bursts with random FIFO arrivals and sink back-pressure.
        for (int b = 0; b < 30; b++) begin
            ln = $urandom_range(9);
            for (int k = $urandom_range(4); k > 0; k--) fifo.push_back(DW'($urandom));
            run_burst(ln, 70, 30, 300, at);
            chk("rnd_pops", 32'(pop_log.size()), 32'(ln));
            cmp_words("rnd_word", pop_log);
            step(0, 0, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
